// File: rtl/prbs_word_gen.sv
// Purpose : PRBS-15 (x^15+x^14+1, Fibonacci) word source for the BER tester; 13-bit words, bit 12 first in time.
// Latency : first word valid one cycle after start is sampled in IDLE; back-to-back words with no bubble after that.
// Backpr. : valid/ready; a word is held stable until it is accepted, and stop never withdraws a presented word.
//
// Ports
//   clk, rst            rising-edge clock; synchronous active-high reset (priority over everything)
//   start               level; begins a burst when sampled in IDLE
//   stop                level; requests early end of the burst (pending word still completes)
//   seed_load, seed     one-cycle strobe + 15-bit seed, honoured only in IDLE (0 -> DEFAULT_SEED)
//   out_ready           downstream accepts data_out
//   out_valid, data_out word handshake toward serializer/loopback
//   word_count          words transferred this burst (saturating, held in IDLE/DONE)
//   busy, done          RUN|STOPPING, DONE
//
// Optional build macro PRBS_ERR_INJECT_EN adds inject_err (in) and inject_count (out): a one-shot
// flag that flips bit 0 of the next transferred word without disturbing the LFSR sequence.

module prbs_word_gen #(
  parameter int          WIDTH        = 13,
  parameter int          NUM_WORDS    = 0,
  parameter logic [14:0] DEFAULT_SEED = 15'h7FFF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             seed_load,
  input  logic [14:0]      seed,
  input  logic             out_ready,
`ifdef PRBS_ERR_INJECT_EN
  input  logic             inject_err,
  output logic [15:0]      inject_count,
`endif
  output logic             out_valid,
  output logic [WIDTH-1:0] data_out,
  output logic [15:0]      word_count,
  output logic             busy,
  output logic             done
);

  localparam logic [15:0] BURST_LEN = 16'(NUM_WORDS);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    STOPPING = 2'd2,
    DONE     = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [14:0]      lfsr;
  logic [14:0]      lfsr_nxt;
  logic [14:0]      lfsr_src;
  logic [14:0]      seed_eff;
  logic [14:0]      adv_lfsr;
  logic [WIDTH-1:0] adv_word;
  logic [WIDTH-1:0] word_q;
  logic [15:0]      count_inc;
  logic [15:0]      count_nxt;
  logic             xfer;
  logic             last_xfer;
  logic             load_word;

  // Run the LFSR WIDTH steps; each new bit is also a word bit, earliest bit in the MSB.
  // Returns {state after the last step, word}.
  function automatic logic [WIDTH+14:0] prbs_advance(input logic [14:0] s_in);
    logic [14:0]      s;
    logic [WIDTH-1:0] w;
    logic             nb;
    s = s_in;
    w = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      nb   = s[14] ^ s[13];
      w[i] = nb;
      s    = {s[13:0], nb};
    end
    return {s, w};
  endfunction

  // Handshake and burst bookkeeping
  assign out_valid = (state == RUN) || (state == STOPPING);
  assign busy      = out_valid;
  assign done      = (state == DONE);
  assign xfer      = out_valid && out_ready;
  assign count_inc = (word_count == 16'hFFFF) ? word_count : word_count + 16'd1;
  // Transfer that completes a finite burst; only meaningful for NUM_WORDS != 0.
  assign last_xfer = (NUM_WORDS != 0) && (count_inc == BURST_LEN);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic. In RUN the burst-complete check comes before stop so that
  // a stop coinciding with the final transfer still lands in DONE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) state_nxt = RUN;
      end
      RUN: begin
        if (xfer && last_xfer) begin
          state_nxt = DONE;
        end else if (stop) begin
          state_nxt = xfer ? IDLE : STOPPING;
        end
      end
      STOPPING: begin
        if (xfer) state_nxt = IDLE;
      end
      DONE: begin
        // wait for start to drop so a held start cannot retrigger a burst
        if (!start) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Word generation. A seed loaded together with start feeds the first word
  // directly, so the burst begins from the new seed in the same cycle.
  always_comb begin
    seed_eff  = (seed == 15'd0) ? DEFAULT_SEED : seed;
    lfsr_src  = ((state == IDLE) && seed_load) ? seed_eff : lfsr;
    {adv_lfsr, adv_word} = prbs_advance(lfsr_src);
    // A new word is produced on burst entry and after every transfer that
    // keeps the burst running; the final/stopping transfer leaves the LFSR
    // parked after the last presented word so the next burst continues from it.
    load_word = ((state == IDLE) && start) ||
                ((state == RUN) && xfer && !last_xfer && !stop);
    lfsr_nxt  = lfsr_src;
    if (load_word) lfsr_nxt = adv_lfsr;

    count_nxt = word_count;
    if ((state == IDLE) && start) begin
      count_nxt = 16'd0;
    end else if (xfer) begin
      count_nxt = count_inc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr       <= DEFAULT_SEED;
      word_q     <= '0;
      word_count <= 16'd0;
    end else begin
      lfsr       <= lfsr_nxt;
      word_count <= count_nxt;
      if (load_word) word_q <= adv_word;
    end
  end

`ifdef PRBS_ERR_INJECT_EN
  logic inj_armed;

  // One-shot: any number of pulses arm a single injection, consumed by the next
  // transfer. A pulse on the consuming cycle itself is absorbed.
  always_ff @(posedge clk) begin
    if (rst) begin
      inj_armed    <= 1'b0;
      inject_count <= 16'd0;
    end else if (xfer && inj_armed) begin
      inj_armed    <= 1'b0;
      inject_count <= (inject_count == 16'hFFFF) ? inject_count : inject_count + 16'd1;
    end else if (inject_err) begin
      inj_armed <= 1'b1;
    end
  end

  // The flip is applied on the output only, leaving word_q/LFSR untouched. Arming
  // while a word is stalled flips bit 0 of that held word, since it is the next
  // one to transfer.
  assign data_out = word_q ^ {{(WIDTH-1){1'b0}}, (inj_armed & out_valid)};
`else
  assign data_out = word_q;
`endif

endmodule

// File: tb/tb_prbs_word_gen.sv
module tb_prbs_word_gen;

  localparam logic [14:0] DEF = 15'h7FFF;

  logic        clk;
  logic        rst, start, stop, seed_load, out_ready;
  logic [14:0] seed;
  logic        out_valid, busy, done;
  logic [12:0] data_out;
  logic [15:0] word_count;

  logic        start4, ready4, zero4;
  logic        v4, busy4, done4;
  logic [12:0] d4;
  logic [15:0] wc4;

`ifdef PRBS_ERR_INJECT_EN
  logic        inject_err, inj4;
  logic [15:0] inject_count, inject_count4;
`endif

  int          tests = 0;
  int          fails = 0;

  // scoreboard state
  logic [12:0] exp_q[$];
  logic [14:0] ep_seed;
  int          ep_idx;
  logic [15:0] exp_cnt;
  bit          inj_pending = 0;

  prbs_word_gen dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .seed_load(seed_load), .seed(seed),
    .out_ready(out_ready),
`ifdef PRBS_ERR_INJECT_EN
    .inject_err(inject_err), .inject_count(inject_count),
`endif
    .out_valid(out_valid), .data_out(data_out), .word_count(word_count), .busy(busy), .done(done)
  );

  prbs_word_gen #(.NUM_WORDS(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .stop(zero4), .seed_load(zero4), .seed(15'd0),
    .out_ready(ready4),
`ifdef PRBS_ERR_INJECT_EN
    .inject_err(inj4), .inject_count(inject_count4),
`endif
    .out_valid(v4), .data_out(d4), .word_count(wc4), .busy(busy4), .done(done4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: the PRBS as a bit stream b[n] = b[n-15] ^ b[n-14], where the
  // 15 seed bits (MSB first) are the history preceding b[0]. Word k is the
  // 13 bits following 13*k, earliest bit in the MSB.
  function automatic logic [12:0] prbs_word(input logic [14:0] sd, input int k);
    bit          b[$];
    logic [12:0] w;
    for (int i = 14; i >= 0; i--) b.push_back(sd[i]);
    while (b.size() < 15 + 13 * (k + 1)) b.push_back(b[b.size() - 15] ^ b[b.size() - 14]);
    for (int j = 0; j < 13; j++) w[12 - j] = b[15 + 13 * k + j];
    return w;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic topup();
    while (exp_q.size() < 4) begin
      exp_q.push_back(prbs_word(ep_seed, ep_idx));
      ep_idx++;
    end
  endtask

  task automatic reseed(input logic [14:0] s);
    exp_q.delete();
    ep_seed = (s == 15'd0) ? DEF : s;
    ep_idx  = 0;
    topup();
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    topup();
  endtask

  // Monitor: pops and compares on every transfer, checks hold-while-stalled and
  // the word count after each transfer.
  initial begin : monitor
    logic        prev_stall, prev_xfer, prev_busy;
    logic [12:0] prev_d, e;
    prev_stall = 0; prev_xfer = 0; prev_busy = 0; prev_d = '0;
    exp_cnt = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 0; prev_xfer = 0; prev_busy = 0;
      end else begin
        if (prev_xfer) check("word_count", word_count, exp_cnt);
        if (busy && !prev_busy) exp_cnt = 16'd0;
        if (prev_stall && out_valid) check("hold_stable", data_out, prev_d);
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            tests++; fails++;
            $display("FAIL stream: unexpected word %0h, expected none", data_out);
          end else begin
            e = exp_q.pop_front();
            if (inj_pending) begin
              e = e ^ 13'h0001;
              inj_pending = 0;
            end
            check("stream", data_out, e);
          end
          if (exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
        end
        prev_xfer  = out_valid && out_ready;
        prev_stall = out_valid && !out_ready;
        prev_d     = data_out;
        prev_busy  = busy;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int          n4;
    logic [14:0] rseed;
    rst = 1; start = 0; stop = 0; seed_load = 0; seed = '0; out_ready = 0;
    start4 = 0; ready4 = 0; zero4 = 0;
`ifdef PRBS_ERR_INJECT_EN
    inject_err = 0; inj4 = 0;
`endif
    reseed(DEF);
    repeat (3) tick();
    check("rst_valid", out_valid, 0);
    check("rst_data", data_out, 0);
    check("rst_count", word_count, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
`ifdef PRBS_ERR_INJECT_EN
    check("rst_inject_count", inject_count, 0);
`endif
    rst = 0;
    tick();

    // finite burst of 4 on the second instance
    start4 = 1; ready4 = 1; n4 = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (v4 && ready4) begin
        check("burst4_word", d4, prbs_word(DEF, n4));
        n4++;
      end
    end
    check("burst4_transfers", n4, 4);
    check("burst4_count", wc4, 4);
    check("burst4_done", done4, 1);
    check("burst4_valid", v4, 0);
    start4 = 0;
    tick();
    check("burst4_idle_done", done4, 0);
    check("burst4_idle_busy", busy4, 0);
    check("burst4_count_hold", wc4, 4);

    // free-running burst, first words from reset seed
    start = 1; out_ready = 1;
    check("valid_before_start", out_valid, 0);
    tick();
    start = 0;
    check("valid_after_start", out_valid, 1);
    check("first_word", data_out, 13'h0000);
    tick();
    check("second_word", data_out, 13'h0800);
    repeat (20) tick();

    // random backpressure; a seed_load in RUN must be ignored
    for (int i = 0; i < 200; i++) begin
      out_ready = 1'($urandom_range(0, 1));
      seed_load = (i == 100);
      seed = 15'h1234;
      tick();
    end
    seed_load = 0;

    // stop while stalled -> STOPPING, one transfer, IDLE
    out_ready = 0;
    tick();
    stop = 1;
    tick();
    stop = 0;
    check("stopping_busy", busy, 1);
    check("stopping_valid", out_valid, 1);
    tick();
    check("stopping_hold_valid", out_valid, 1);
    out_ready = 1;
    tick();
    out_ready = 0;
    check("after_stopping_valid", out_valid, 0);
    check("after_stopping_busy", busy, 0);
    tick();

    // new burst continues the sequence; stop with a transfer goes straight to IDLE
    start = 1; out_ready = 1;
    tick();
    start = 0;
    repeat (5) tick();
    stop = 1;
    tick();
    stop = 0;
    check("stop_xfer_valid", out_valid, 0);
    check("stop_xfer_busy", busy, 0);

    // zero seed restores the reset sequence
    seed_load = 1; seed = 15'd0;
    tick();
    seed_load = 0;
    reseed(15'd0);
    start = 1; out_ready = 1;
    tick();
    start = 0;
    check("seed0_first", data_out, 13'h0000);
    tick();
    check("seed0_second", data_out, 13'h0800);
    repeat (5) tick();
    stop = 1;
    tick();
    stop = 0;

    // seed_load together with start: burst uses the new random seed
    rseed = 15'($urandom_range(1, 32767));
    seed_load = 1; seed = rseed; start = 1; out_ready = 1;
    reseed(rseed);
    tick();
    seed_load = 0; start = 0;
    check("seed_start_first", data_out, prbs_word(rseed, 0));
    for (int i = 0; i < 30; i++) begin
      out_ready = 1'($urandom_range(0, 1));
      tick();
    end
    out_ready = 1;
    stop = 1;
    tick();
    stop = 0;
    tick();

    // reset mid-RUN
    start = 1; out_ready = 1;
    tick();
    start = 0;
    repeat (3) tick();
    out_ready = 0;
    tick();
    rst = 1;
    tick();
    check("midrst_valid", out_valid, 0);
    check("midrst_data", data_out, 0);
    check("midrst_count", word_count, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    rst = 0;
    reseed(DEF);
    tick();
    start = 1; out_ready = 1;
    tick();
    start = 0;
    check("postrst_first", data_out, 13'h0000);
    repeat (5) tick();
    stop = 1;
    tick();
    stop = 0;
    tick();

`ifdef PRBS_ERR_INJECT_EN
    // two pulses before a transfer inject once
    out_ready = 0;
    inject_err = 1; tick(); inject_err = 0; tick();
    inject_err = 1; tick(); inject_err = 0;
    inj_pending = 1;
    start = 1; out_ready = 1;
    tick();
    start = 0;
    repeat (3) tick();
    check("inject_count", inject_count, 1);
    stop = 1;
    tick();
    stop = 0;
    tick();
`endif

    out_ready = 0;
    repeat (2) tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/prbs_word_gen.md
Name: prbs_word_gen

Overview:
- Transmit-side pattern source for the bit-error-ratio tester.
- Generates the 13-bit PRBS-15 words that the link transmits; the comparator checks the received stream against the same sequence.
- Supplies words to the serializer/loopback path over a valid/ready handshake.
- Counts the words it has transferred and stops after a programmed burst length.

Parameters:
- WIDTH, 13: word width; fixed to match the comparator; other values unsupported.
- NUM_WORDS, 0: burst length in words; 0 = run until stop.
- DEFAULT_SEED, 15'h7FFF: LFSR value after reset; also substituted for any zero seed.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  level; sampled in IDLE to begin a burst.
- stop  in  1  level; requests an early end of the burst.
- seed_load  in  1  one-cycle strobe; loads seed into the LFSR, honoured only in IDLE.
- seed  in  15  LFSR seed value.
- out_ready  in  1  downstream accepts the word.
- out_valid  out  1  data_out is valid.
- data_out  out  WIDTH  PRBS word; bit 12 is first in time.
- word_count  out  16  words transferred this burst.
- busy  out  1  high in RUN and STOPPING.
- done  out  1  high in DONE.

Behaviour:
- Reset values: out_valid=0, data_out=0, word_count=0, busy=0, done=0, LFSR=DEFAULT_SEED, state=IDLE.
- rst has priority over every input.
- rst during RUN aborts immediately; no further word is presented.
- Polynomial x^15+x^14+1 in Fibonacci form:
  - one step: nb = s[14]^s[13]; s <= {s[13:0], nb}.
  - one word = 13 successive steps; the first nb goes to data_out[12], the last to data_out[0].
  - the LFSR holds the state after the last step of the presented word.
- States:
  - IDLE:
    - seed_load loads seed; a seed of 0 loads DEFAULT_SEED.
    - start=1 -> RUN and clear word_count.
    - if seed_load and start are both high, the load takes effect first and the burst uses the new seed.
  - RUN:
    - out_valid=1.
    - The first word is registered on entry, so out_valid rises one cycle after start is sampled.
    - Transfer = out_valid&&out_ready. On a transfer:
      - the next word appears the following cycle, giving zero-bubble streaming;
      - word_count increments and saturates at 16'hFFFF.
    - While out_valid && !out_ready, data_out is held stable.
    - NUM_WORDS!=0 and a transfer that makes word_count==NUM_WORDS -> DONE; out_valid falls the next cycle.
    - stop=1: if there is no transfer this cycle -> STOPPING; if there is a transfer this cycle -> IDLE. stop never withdraws a valid word.
    - If stop arrives on the cycle the final NUM_WORDS transfer completes, DONE wins.
  - STOPPING:
    - out_valid stays 1 and data_out is held.
    - The pending transfer completes: word_count increments -> IDLE.
  - DONE:
    - done=1, out_valid=0.
    - Stays until start=0 -> IDLE, so a held start does not retrigger.
- The LFSR is not reset between bursts: the next burst continues the sequence unless seed_load is used.
- seed_load outside IDLE is ignored.
- word_count holds its value in IDLE and DONE until the next burst starts.

Optional Feature:
- Macro: PRBS_ERR_INJECT_EN.
- Defined:
  - Adds input inject_err (1) and output inject_count (16, reset 0).
  - An inject_err pulse in any state arms a one-shot flag.
  - The next transferred word is XORed with 13'h0001; the LFSR sequence is unaffected.
  - The flag clears and inject_count increments (saturating) on that transfer.
  - Several pulses before one transfer still inject only once.
- Undefined: neither port exists; data_out is the pure PRBS word.

Test Plan:
- Reset, then start=1 with out_ready=1 held -> out_valid one cycle later; first word 13'h0000, second 13'h0800; subsequent words match the reference model; word_count increments each cycle.
- out_ready toggled randomly -> data_out stable while out_valid&&!out_ready; no word skipped or duplicated against the model.
- NUM_WORDS=4, out_ready=1 -> exactly 4 transfers, word_count=4, done=1, out_valid=0; start held high stays in DONE; start=0 returns to IDLE.
- seed_load with seed=0 in IDLE, then start -> same first words as after reset (13'h0000, 13'h0800); seed_load with seed=15'h1234 during RUN is ignored.
- stop asserted while out_valid=1 and out_ready=0 -> STOPPING with data held; out_ready=1 -> one transfer, word_count+1, IDLE; a rst pulse mid-RUN -> every output returns to its reset value the next cycle.
- PRBS_ERR_INJECT_EN defined: two inject_err pulses before a transfer -> only the next word has bit 0 inverted, inject_count=1; the following word matches the model.
